// File: rtl/regs.sv
// 2-read/1-write register file with r0 hardwired to zero; reads are combinational (0 cycles),
// writes commit on the rising clk edge; no backpressure, a write is accepted every cycle we is high.
module regs #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] Rs_addr_A,
  input  logic [ADDR_W-1:0] Rd_addr_B,
  input  logic [ADDR_W-1:0] Wt_addr,
  input  logic [DATA_W-1:0] wt_data,
  output logic [DATA_W-1:0] rdata_A,
  output logic [DATA_W-1:0] rdata_B
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_en;

  // Writes to address 0 are dropped here so r0 never holds anything but zero.
  assign wr_en = we && (Wt_addr != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[Wt_addr] <= wt_data;
    end
  end

  // No bypass: a same-cycle write shows up only after its committing edge.
  assign rdata_A = (Rs_addr_A == '0) ? '0 : mem[Rs_addr_A];
  assign rdata_B = (Rd_addr_B == '0) ? '0 : mem[Rd_addr_B];

endmodule

// File: tb/tb_regs.sv
// Scoreboard bench for regs: stimulus queues expected read data, a monitor compares on each strobe.
module tb_regs;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  Rs_addr_A;
  logic [4:0]  Rd_addr_B;
  logic [4:0]  Wt_addr;
  logic [31:0] wt_data;
  logic [31:0] rdata_A;
  logic [31:0] rdata_B;

  regs #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .we        (we),
    .Rs_addr_A (Rs_addr_A),
    .Rd_addr_B (Rd_addr_B),
    .Wt_addr   (Wt_addr),
    .wt_data   (wt_data),
    .rdata_A   (rdata_A),
    .rdata_B   (rdata_B)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  string       name_q [$];
  logic [31:0] expa_q [$];
  logic [31:0] expb_q [$];
  logic        chk_vld;
  int          checks;
  int          failures;

  initial begin
    checks   = 0;
    failures = 0;
  end

  // Monitor: each strobe means the read ports hold a result the scoreboard predicted.
  initial begin
    string       n;
    logic [31:0] ea;
    logic [31:0] eb;
    forever begin
      @(posedge chk_vld);
      if (name_q.size() == 0) begin
        failures++;
        $display("FAIL monitor: strobe with empty scoreboard, rdata_A=%h rdata_B=%h", rdata_A, rdata_B);
      end else begin
        n  = name_q.pop_front();
        ea = expa_q.pop_front();
        eb = expb_q.pop_front();
        checks++;
        if (rdata_A !== ea || rdata_B !== eb) begin
          failures++;
          $display("FAIL %s: got rdata_A=%h rdata_B=%h, expected A=%h B=%h", n, rdata_A, rdata_B, ea, eb);
        end
      end
    end
  end

  task automatic expect_rd(input string n, input logic [31:0] ea, input logic [31:0] eb);
    name_q.push_back(n);
    expa_q.push_back(ea);
    expb_q.push_back(eb);
    chk_vld = 1'b1;
    #1;
    chk_vld = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    we      = 1'b1;
    Wt_addr = a;
    wt_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string n, input logic [4:0] a, input logic [4:0] b,
                    input logic [31:0] ea, input logic [31:0] eb);
    @(negedge clk);
    we        = 1'b0;
    Rs_addr_A = a;
    Rd_addr_B = b;
    #1;
    expect_rd(n, ea, eb);
  endtask

  initial begin
    chk_vld   = 1'b0;
    rst       = 1'b1;
    we        = 1'b0;
    Rs_addr_A = '0;
    Rd_addr_B = '0;
    Wt_addr   = '0;
    wt_data   = '0;
    #20;
    rst = 1'b0;

    // Every address on both ports reads zero after reset.
    for (int i = 0; i < 32; i++) begin
      rd("reset_all", 5'(i), 5'(31 - i), 32'h0, 32'h0);
    end

    wr(5'd5, 32'd5);
    wr(5'd6, 32'd6);
    wr(5'd7, 32'd7);
    @(negedge clk);
    we        = 1'b0;
    wt_data   = '0;
    Rs_addr_A = 5'd5;
    Rd_addr_B = 5'd6;
    #1;
    expect_rd("rd_r5_r6", 32'd5, 32'd6);
    Rs_addr_A = 5'd7;
    #1;
    expect_rd("rd_r7", 32'd7, 32'd6);
    rd("same_addr", 5'd7, 5'd7, 32'd7, 32'd7);

    wr(5'd0, 32'hFFFF_FFFF);
    rd("r0_hardwired", 5'd0, 5'd5, 32'h0, 32'd5);

    // we low: address and data toggling must not touch r5.
    @(negedge clk);
    we      = 1'b0;
    Wt_addr = 5'd5;
    wt_data = 32'hDEAD_BEEF;
    repeat (3) @(posedge clk);
    #1;
    rd("we_low_hold", 5'd5, 5'd6, 32'd5, 32'd6);

    // Same-cycle read/write of r9: old value before the edge, new after.
    @(negedge clk);
    Rs_addr_A = 5'd9;
    Rd_addr_B = 5'd9;
    we        = 1'b1;
    Wt_addr   = 5'd9;
    wt_data   = 32'h1234_5678;
    #1;
    expect_rd("no_bypass_before", 32'h0, 32'h0);
    @(posedge clk);
    #1;
    expect_rd("no_bypass_after", 32'h1234_5678, 32'h1234_5678);
    rd("other_regs_hold", 5'd5, 5'd7, 32'd5, 32'd7);

    wr(5'd5, 32'hA5A5_A5A5);
    rd("overwrite_r5", 5'd5, 5'd31, 32'hA5A5_A5A5, 32'h0);
    wr(5'd31, 32'h8000_0001);
    rd("top_addr", 5'd31, 5'd6, 32'h8000_0001, 32'd6);

    // Asynchronous reset between edges clears outputs before the next edge.
    rd("pre_reset", 5'd5, 5'd7, 32'hA5A5_A5A5, 32'd7);
    #1;
    rst = 1'b1;
    #1;
    expect_rd("async_reset", 32'h0, 32'h0);

    // Writes blocked while reset is held.
    Rs_addr_A = 5'd3;
    Rd_addr_B = 5'd31;
    we        = 1'b1;
    Wt_addr   = 5'd3;
    wt_data   = 32'h0000_0033;
    @(posedge clk);
    @(negedge clk);
    we  = 1'b0;
    rst = 1'b0;
    #1;
    expect_rd("write_blocked_in_reset", 32'h0, 32'h0);

    wr(5'd3, 32'h0000_0033);
    rd("first_write_after_reset", 5'd3, 5'd5, 32'h0000_0033, 32'h0);
    rd("contents_discarded", 5'd9, 5'd7, 32'h0, 32'h0);

    #5;
    if (name_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", name_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
